seizure_score_sequencer: RTL and testbench

- Time-multiplexed controller for the linear seizure classifier.
- Holds the 96 signed feature-bit weights (16 bit positions × 6 features) in a writable register file.
- Accepts one feature frame per valid/ready handshake and walks all 96 weights through a single shared adder, one per cycle.
- Returns the signed score and the threshold decision on a valid/ready output. Replaces the fully parallel adder tree with one adder, for area-constrained builds.

---
 rtl/seizure_score_sequencer.sv | 147 ++++++++++++++
 tb/tb_seizure_score_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seizure_score_sequencer.sv
// Time-multiplexed linear seizure classifier: one shared adder walks the 96
// feature-bit weights of a captured frame, then presents score and decision.
module seizure_score_sequencer #(
    parameter int WEIGHT_W = 12,
    parameter int ACC_W    = 20,
    parameter int NBITS    = 16,
    parameter int NFEAT    = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [6:0]                 cfg_addr,
    input  logic signed [WEIGHT_W-1:0] cfg_wdata,
    input  logic                       thr_we,
    input  logic signed [ACC_W-1:0]    thr_wdata,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NBITS-1:0]           ll,
    input  logic [NBITS-1:0]           ne,
    input  logic [NBITS-1:0]           ps,
    input  logic [NBITS-1:0]           theta,
    input  logic [NBITS-1:0]           alpha,
    input  logic [NBITS-1:0]           beta,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_W-1:0]    score,
    output logic                       seizure,
    output logic                       busy
);
    localparam int NW     = NBITS * NFEAT;
    localparam int IDX_W  = $clog2(NW);
    localparam int FEAT_W = $clog2(NFEAT);
    localparam int BIT_W  = $clog2(NBITS);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NW - 1);
    localparam logic [FEAT_W-1:0]       LAST_FEAT = FEAT_W'(NFEAT - 1);
    localparam logic signed [ACC_W-1:0] THR_RST  = {1'b0, {(ACC_W-1){1'b1}}};

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready is high only in IDLE, out_valid only in OUT.
    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                      state_q, state_d;
    logic signed [WEIGHT_W-1:0]  w_q [NW];
    logic signed [ACC_W-1:0]     thr_q;
    logic [NBITS-1:0]            frame_q [NFEAT];
    logic [IDX_W-1:0]            idx_q;
    logic [FEAT_W-1:0]           feat_q;
    logic [BIT_W-1:0]            bit_q;
    logic signed [ACC_W-1:0]     acc_q;
    logic signed [ACC_W-1:0]     score_q;
    logic                        seizure_q;

    logic signed [WEIGHT_W-1:0]  wsel;
    logic signed [ACC_W-1:0]     addend;
    logic signed [ACC_W-1:0]     sum;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = ACCUM;
            end
            ACCUM: begin
                if (idx_q == LAST_IDX) state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Feature (idx mod 6) / bit (idx div 6) are tracked as separate counters
    // alongside the flat weight index, so no divider is needed.
    always_comb begin
        wsel   = w_q[idx_q];
        addend = '0;
        if (frame_q[feat_q][bit_q]) addend = {{(ACC_W-WEIGHT_W){wsel[WEIGHT_W-1]}}, wsel};
        sum = acc_q + addend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            idx_q     <= '0;
            feat_q    <= '0;
            bit_q     <= '0;
            score_q   <= '0;
            seizure_q <= 1'b0;
            for (int i = 0; i < NFEAT; i++) frame_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        frame_q[0] <= ll;
                        frame_q[1] <= ne;
                        frame_q[2] <= ps;
                        frame_q[3] <= theta;
                        frame_q[4] <= alpha;
                        frame_q[5] <= beta;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        feat_q     <= '0;
                        bit_q      <= '0;
                    end
                end
                ACCUM: begin
                    acc_q <= sum;
                    idx_q <= idx_q + 1'b1;
                    if (feat_q == LAST_FEAT) begin
                        feat_q <= '0;
                        bit_q  <= bit_q + 1'b1;
                    end else begin
                        feat_q <= feat_q + 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        score_q   <= sum;
                        seizure_q <= (sum >= thr_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Configuration only lands in IDLE so an in-flight frame sees one weight set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) w_q[i] <= '0;
            thr_q <= THR_RST;
        end else if (state_q == IDLE) begin
            if (cfg_we && (32'(cfg_addr) < NW)) w_q[cfg_addr] <= cfg_wdata;
            if (thr_we) thr_q <= thr_wdata;
        end
    end

    assign score   = score_q;
    assign seizure = seizure_q;
endmodule

// File: tb/tb_seizure_score_sequencer.sv
// Directed self-checking bench for seizure_score_sequencer.
module tb_seizure_score_sequencer;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_we = 1'b0;
    logic [6:0]         cfg_addr = '0;
    logic signed [11:0] cfg_wdata = '0;
    logic               thr_we = 1'b0;
    logic signed [19:0] thr_wdata = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [15:0]        ll = '0, ne = '0, ps = '0, theta = '0, alpha = '0, beta = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [19:0] score;
    logic               seizure;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    seizure_score_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .thr_we(thr_we), .thr_wdata(thr_wdata),
        .in_valid(in_valid), .in_ready(in_ready),
        .ll(ll), .ne(ne), .ps(ps), .theta(theta), .alpha(alpha), .beta(beta),
        .out_valid(out_valid), .out_ready(out_ready),
        .score(score), .seizure(seizure), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cfg_we = 1'b0; thr_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [6:0] a, input logic signed [11:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic thr_write(input logic signed [19:0] t);
        @(negedge clk);
        thr_we = 1'b1; thr_wdata = t;
        @(negedge clk);
        thr_we = 1'b0;
    endtask

    // Sends one frame from IDLE and waits (bounded) for out_valid.
    // acc_cfg: write weight[0]=acc_data on the accepting edge.
    // inj_at: cycle inside ACCUM at which a weight[0]=500 / thr=-1000 write is attempted.
    task automatic run_frame(input logic [15:0] v0, v1, v2, v3, v4, v5,
                             input bit acc_cfg, input logic signed [11:0] acc_data,
                             input int inj_at,
                             output int lat, output logic signed [19:0] sc,
                             output logic sz, output logic mid_busy, output logic mid_rdy);
        @(negedge clk);
        ll = v0; ne = v1; ps = v2; theta = v3; alpha = v4; beta = v5;
        in_valid = 1'b1;
        if (acc_cfg) begin
            cfg_we = 1'b1; cfg_addr = 7'd0; cfg_wdata = acc_data;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we = 1'b0;
        lat = 0;
        mid_busy = 1'b0;
        mid_rdy = 1'b1;
        while (!out_valid && lat < 200) begin
            if (lat == inj_at) begin
                cfg_we = 1'b1; cfg_addr = 7'd0; cfg_wdata = 12'sd500;
                thr_we = 1'b1; thr_wdata = -20'sd1000;
            end
            @(posedge clk);
            #1;
            cfg_we = 1'b0;
            thr_we = 1'b0;
            lat++;
            if (lat == 50) begin
                mid_busy = busy;
                mid_rdy = in_ready;
            end
        end
        sc = score;
        sz = seizure;
    endtask

    task automatic pop_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // ---------------- test tasks ----------------
    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (score !== 20'sd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
        n_checks++; if (seizure !== 1'b0) begin n_fail++; $display("FAIL reset_seizure: got %b expected 0", seizure); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_no_config();
        int lat; logic signed [19:0] sc; logic sz, mb, mr;
        run_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 12'sd0, -1,
                  lat, sc, sz, mb, mr);
        n_checks++; if (lat !== 96) begin n_fail++; $display("FAIL noconf_latency: got %0d expected 96", lat); end
        n_checks++; if (sc !== 20'sd0) begin n_fail++; $display("FAIL noconf_score: got %0d expected 0", sc); end
        n_checks++; if (sz !== 1'b0) begin n_fail++; $display("FAIL noconf_seizure: got %b expected 0", sz); end
        n_checks++; if (mb !== 1'b1 || mr !== 1'b0) begin n_fail++; $display("FAIL noconf_mid_accum: busy %b in_ready %b expected 1 0", mb, mr); end
        pop_result();
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL noconf_back_idle: busy %b out_valid %b expected 0 0", busy, out_valid); end
    endtask

    task automatic test_two_weights();
        int lat; logic signed [19:0] sc; logic sz, mb, mr;
        cfg_write(7'd0, 12'sd100);
        cfg_write(7'd95, -12'sd30);
        thr_write(20'sd70);
        run_frame(16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 1'b0, 12'sd0, -1, lat, sc, sz, mb, mr);
        n_checks++; if (sc !== 20'sd70) begin n_fail++; $display("FAIL two_w_score_a: got %0d expected 70", sc); end
        n_checks++; if (sz !== 1'b1) begin n_fail++; $display("FAIL two_w_seizure_a: got %b expected 1", sz); end
        pop_result();
        run_frame(16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, 1'b0, 12'sd0, -1, lat, sc, sz, mb, mr);
        n_checks++; if (sc !== 20'sd100) begin n_fail++; $display("FAIL two_w_score_b: got %0d expected 100", sc); end
        n_checks++; if (sz !== 1'b1) begin n_fail++; $display("FAIL two_w_seizure_b: got %b expected 1", sz); end
        pop_result();
        thr_write(20'sd101);
        run_frame(16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, 1'b0, 12'sd0, -1, lat, sc, sz, mb, mr);
        n_checks++; if (sc !== 20'sd100) begin n_fail++; $display("FAIL two_w_score_c: got %0d expected 100", sc); end
        n_checks++; if (sz !== 1'b0) begin n_fail++; $display("FAIL two_w_seizure_c: got %b expected 0", sz); end
        pop_result();
    endtask

    task automatic test_backpressure();
        int lat; logic signed [19:0] sc; logic sz, mb, mr;
        int lat2;
        // weights w0=100, w95=-30, thr=101 -> score 70, no seizure
        run_frame(16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 1'b0, 12'sd0, -1, lat, sc, sz, mb, mr);
        n_checks++; if (sc !== 20'sd70 || sz !== 1'b0) begin n_fail++; $display("FAIL bp_result: got %0d/%b expected 70/0", sc, sz); end
        // second frame offered while result is held
        ll = 16'h0001; beta = 16'h0000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (score !== 20'sd70 || seizure !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: score %0d seizure %b out_valid %b in_ready %b expected 70 0 1 0",
                         i, score, seizure, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || score !== 20'sd70) begin n_fail++; $display("FAIL bp_release: in_ready %b out_valid %b score %0d expected 1 0 70", in_ready, out_valid, score); end
        // in_valid still high: accepted on the next edge, result 97 edges after release
        lat2 = 0;
        while (!out_valid && lat2 < 200) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat2++;
        end
        n_checks++; if (lat2 !== 97) begin n_fail++; $display("FAIL bp_second_latency: got %0d expected 97", lat2); end
        n_checks++; if (score !== 20'sd100 || seizure !== 1'b0) begin n_fail++; $display("FAIL bp_second_result: got %0d/%b expected 100/0", score, seizure); end
        pop_result();
    endtask

    task automatic test_cfg_during_accum();
        int lat; logic signed [19:0] sc; logic sz, mb, mr;
        run_frame(16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 12'sd0, 10, lat, sc, sz, mb, mr);
        n_checks++; if (sc !== 20'sd100) begin n_fail++; $display("FAIL accum_cfg_score: got %0d expected 100", sc); end
        n_checks++; if (sz !== 1'b0) begin n_fail++; $display("FAIL accum_thr_ignored: got %b expected 0", sz); end
        pop_result();
        run_frame(16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 12'sd0, -1, lat, sc, sz, mb, mr);
        n_checks++; if (sc !== 20'sd100) begin n_fail++; $display("FAIL accum_cfg_next_score: got %0d expected 100", sc); end
        pop_result();
        cfg_write(7'd0, 12'sd500);
        run_frame(16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 12'sd0, -1, lat, sc, sz, mb, mr);
        n_checks++; if (sc !== 20'sd500 || sz !== 1'b1) begin n_fail++; $display("FAIL idle_cfg_result: got %0d/%b expected 500/1", sc, sz); end
        pop_result();
    endtask

    task automatic test_all_negative();
        int lat; logic signed [19:0] sc; logic sz, mb, mr;
        for (int i = 0; i < 95; i++) cfg_write(7'(i), -12'sd2048);
        // last weight and threshold land on the same edge
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 7'd95; cfg_wdata = -12'sd2048;
        thr_we = 1'b1; thr_wdata = -20'sd196608;
        @(negedge clk);
        cfg_we = 1'b0; thr_we = 1'b0;
        run_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 12'sd0, -1, lat, sc, sz, mb, mr);
        n_checks++; if (sc !== -20'sd196608) begin n_fail++; $display("FAIL neg_score: got %0d expected -196608", sc); end
        n_checks++; if (sz !== 1'b1) begin n_fail++; $display("FAIL neg_seizure_equal: got %b expected 1", sz); end
        pop_result();
        thr_write(-20'sd196607);
        run_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 12'sd0, -1, lat, sc, sz, mb, mr);
        n_checks++; if (sc !== -20'sd196608 || sz !== 1'b0) begin n_fail++; $display("FAIL neg_below_thr: got %0d/%b expected -196608/0", sc, sz); end
        pop_result();
        // weight[0]=0 written on the accepting edge is used by that frame
        run_frame(16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 12'sd0, -1, lat, sc, sz, mb, mr);
        n_checks++; if (sc !== 20'sd0 || sz !== 1'b1) begin n_fail++; $display("FAIL accept_cfg_same_edge: got %0d/%b expected 0/1", sc, sz); end
        pop_result();
    endtask

    task automatic test_reset_mid_frame();
        int lat; logic signed [19:0] sc; logic sz, mb, mr;
        @(negedge clk);
        ll = 16'hFFFF; ne = 16'hFFFF; ps = 16'hFFFF; theta = 16'hFFFF; alpha = 16'hFFFF; beta = 16'hFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ctrl: out_valid %b busy %b in_ready %b expected 0 0 1", out_valid, busy, in_ready); end
        n_checks++; if (seizure !== 1'b0 || score !== 20'sd0) begin n_fail++; $display("FAIL midrst_outputs: score %0d seizure %b expected 0 0", score, seizure); end
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 12'sd0, -1, lat, sc, sz, mb, mr);
        n_checks++; if (lat !== 96) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 96", lat); end
        n_checks++; if (sc !== 20'sd0 || sz !== 1'b0) begin n_fail++; $display("FAIL midrst_weights_cleared: got %0d/%b expected 0/0", sc, sz); end
        pop_result();
    endtask

    initial begin
        test_reset();
        test_no_config();
        test_two_weights();
        test_backpressure();
        test_cfg_during_accum();
        test_all_negative();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
